// File: rtl/first8_cluster_collector.sv
// first8_cluster_collector: samples the eight mux addresses per finder half-cycle into frames buffered in a FWFT FIFO
module first8_cluster_collector #(
  parameter int SAMPLE_A    = 3,
  parameter int SAMPLE_B    = 7,
  parameter int FIFO_DEPTH  = 4,
  parameter int WRITE_EMPTY = 0
) (
  input  logic        clock4x,
  input  logic        global_reset,
  input  logic [10:0] adr0,
  input  logic [10:0] adr1,
  input  logic [10:0] adr2,
  input  logic [10:0] adr3,
  input  logic [10:0] adr4,
  input  logic [10:0] adr5,
  input  logic [10:0] adr6,
  input  logic [10:0] adr7,
  input  logic        clr_status,
  output logic        frame_valid,
  input  logic        frame_ready,
  output logic [3:0]  frame_count,
  output logic [7:0]  frame_seq,
  output logic        frame_half,
  output logic [87:0] frame_adr,
  output logic        overflow,
  output logic [7:0]  drop_cnt,
  output logic        order_err
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int FW = 101;
  logic [2:0] phase;
  logic [7:0] seq, s1_seq;
  logic [87:0] adr_bus, s1_adr, bld_adr;
  logic [7:0] in_vld, s1_vld;
  logic s1_v, s1_half, bld_err, cap, push, pop, full, empty, drop, wr_en;
  logic [3:0] bld_cnt;
  logic [AW:0] wr_ptr, rd_ptr;
  logic [FW-1:0] mem [FIFO_DEPTH];
  logic [FW-1:0] head;
  assign adr_bus = {adr7, adr6, adr5, adr4, adr3, adr2, adr1, adr0};
  assign cap = phase == 3'(SAMPLE_A) || phase == 3'(SAMPLE_B);
  always_comb begin
    in_vld = '0;
    bld_adr = '0;
    bld_err = 1'b0;
    for (int k = 0; k < 8; k++) begin
      in_vld[k] = adr_bus[11*k +: 11] < 11'd1536;
      bld_adr[11*k +: 11] = s1_vld[k] ? s1_adr[11*k +: 11] : 11'h7FF;
    end
    // valid slots must form an ascending prefix: no hit after a gap, no repeat or descent
    for (int k = 1; k < 8; k++)
      bld_err = bld_err | (s1_vld[k] & (!s1_vld[k-1] | (s1_adr[11*k +: 11] <= s1_adr[11*(k-1) +: 11])));
  end
  assign bld_cnt = 4'($countones(s1_vld));
  assign empty = wr_ptr == rd_ptr;
  assign full = wr_ptr == {~rd_ptr[AW], rd_ptr[AW-1:0]};
  assign frame_valid = !empty;
  assign pop = frame_valid & frame_ready;
  assign push = s1_v & ((bld_cnt != 4'd0) | (WRITE_EMPTY != 0));
  assign drop = push & full & !pop;
  assign wr_en = push & !drop;
  assign head = frame_valid ? mem[rd_ptr[AW-1:0]] : '0;
  assign {frame_half, frame_seq, frame_count, frame_adr} = head;
  always_ff @(posedge clock4x or posedge global_reset) begin
    if (global_reset) begin
      phase <= '0;
      seq <= '0;
      s1_v <= 1'b0;
      s1_half <= 1'b0;
      s1_seq <= '0;
      s1_adr <= '0;
      s1_vld <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      overflow <= 1'b0;
      drop_cnt <= '0;
      order_err <= 1'b0;
    end else begin
      phase <= phase + 3'd1;
      s1_v <= cap;
      if (cap) begin
        s1_adr <= adr_bus;
        s1_vld <= in_vld;
        s1_half <= phase != 3'(SAMPLE_A);
        s1_seq <= seq;
        seq <= seq + 8'd1;
      end
      if (wr_en) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop) rd_ptr <= rd_ptr + (AW+1)'(1);
      overflow <= (overflow & !clr_status) | drop;
      drop_cnt <= drop ? (clr_status ? 8'd1 : (drop_cnt == 8'hFF ? drop_cnt : drop_cnt + 8'd1))
                       : (clr_status ? 8'd0 : drop_cnt);
      order_err <= (order_err & !clr_status) | (s1_v & bld_err);
    end
  end
  always_ff @(posedge clock4x)
    if (wr_en) mem[wr_ptr[AW-1:0]] <= {s1_half, s1_seq, bld_cnt, bld_adr};
endmodule

// File: tb/tb_first8_cluster_collector.sv
// tb_first8_cluster_collector: random and directed stimulus against a sample-level frame model with a scoreboard monitor
module tb_first8_cluster_collector;
  localparam int SA = 3;
  localparam int SB = 7;
  localparam int DEPTH = 4;
  localparam int WE = 0;
  typedef struct packed {
    logic        half;
    logic [7:0]  seq;
    logic [3:0]  cnt;
    logic [87:0] adr;
  } frame_t;
  logic clock4x = 1'b0;
  logic global_reset = 1'b1;
  logic [10:0] adr [8];
  logic clr_status = 1'b0;
  logic frame_ready = 1'b0;
  logic frame_valid, frame_half, overflow, order_err;
  logic [3:0] frame_count;
  logic [7:0] frame_seq, drop_cnt;
  logic [87:0] frame_adr;
  int tests = 0;
  int fails = 0;
  int n_rx = 0;
  int mph, occ, m_dc;
  logic [7:0] mseq;
  bit pend_v, pend_err, m_ovf, m_oerr;
  frame_t pend;
  frame_t exp_q [$];

  first8_cluster_collector #(.SAMPLE_A(SA), .SAMPLE_B(SB), .FIFO_DEPTH(DEPTH), .WRITE_EMPTY(WE)) dut (
    .clock4x(clock4x), .global_reset(global_reset),
    .adr0(adr[0]), .adr1(adr[1]), .adr2(adr[2]), .adr3(adr[3]),
    .adr4(adr[4]), .adr5(adr[5]), .adr6(adr[6]), .adr7(adr[7]),
    .clr_status(clr_status), .frame_valid(frame_valid), .frame_ready(frame_ready),
    .frame_count(frame_count), .frame_seq(frame_seq), .frame_half(frame_half),
    .frame_adr(frame_adr), .overflow(overflow), .drop_cnt(drop_cnt), .order_err(order_err)
  );

  always #5 clock4x = ~clock4x;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Effect of the clock edge just passed, computed from the inputs that were held before it
  task automatic model_edge();
    frame_t f;
    int n;
    bit pop, psh, err;
    if (global_reset) begin
      mph = 0; occ = 0; mseq = '0; pend_v = 0; pend_err = 0;
      m_ovf = 0; m_dc = 0; m_oerr = 0;
      exp_q.delete();
      return;
    end
    pop = occ > 0 && frame_ready;
    psh = 0;
    if (clr_status) begin m_ovf = 0; m_dc = 0; m_oerr = 0; end
    if (pend_v) begin
      if (pend_err) m_oerr = 1;
      if (pend.cnt != 0 || WE != 0) begin
        if (occ == DEPTH && !pop) begin
          m_ovf = 1;
          if (m_dc < 255) m_dc++;
        end else begin
          exp_q.push_back(pend);
          psh = 1;
        end
      end
    end
    occ = occ + int'(psh) - int'(pop);
    pend_v = 0;
    if (mph == SA || mph == SB) begin
      n = 0; err = 0; f = '0;
      for (int k = 0; k < 8; k++) begin
        if (adr[k] < 1536) n++;
        f.adr[11*k +: 11] = adr[k] < 1536 ? adr[k] : 11'h7FF;
      end
      for (int k = 0; k < n; k++) if (adr[k] >= 1536) err = 1;
      for (int k = 1; k < n; k++) if (adr[k] <= adr[k-1]) err = 1;
      f.cnt = 4'(n); f.seq = mseq; f.half = (mph == SB);
      pend = f; pend_err = err; pend_v = 1;
      mseq = mseq + 8'd1;
    end
    mph = (mph + 1) % 8;
  endtask

  task automatic tick();
    @(posedge clock4x);
    #1;
    model_edge();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic set_adr(input int a0, input int a1);
    for (int k = 0; k < 8; k++) adr[k] = 11'h7FF;
    adr[0] = 11'(a0);
    adr[1] = 11'(a1);
  endtask

  task automatic rand_adr();
    int m = $urandom_range(0, 3);
    int b = $urandom_range(0, 100);
    int n = $urandom_range(0, 8);
    for (int k = 0; k < 8; k++) adr[k] = 11'h7FF;
    if (m == 1 || m == 3) begin
      if (m == 3) n = 8;
      for (int k = 0; k < n; k++) begin
        b += $urandom_range(1, 150);
        adr[k] = 11'(b);
      end
    end else if (m == 2) begin
      for (int k = 0; k < 8; k++) adr[k] = $urandom_range(0, 1) ? 11'($urandom_range(0, 2047)) : 11'h7FF;
    end
  endtask

  task automatic do_reset();
    #2 global_reset = 1'b1;
    #1 chk("async_reset_valid", frame_valid, 0);
    ticks(2);
    global_reset = 1'b0;
  endtask

  // Scoreboard monitor: compares whenever the DUT presents a frame, pops on handshake
  always @(negedge clock4x) begin
    if (!global_reset) begin
      chk("frame_valid", frame_valid, occ > 0);
      chk("overflow", overflow, m_ovf);
      chk("drop_cnt", drop_cnt, m_dc);
      chk("order_err", order_err, m_oerr);
      if (frame_valid) begin
        if (exp_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_frame: got seq %0h expected none", frame_seq);
        end else begin
          chk("frame_half", frame_half, exp_q[0].half);
          chk("frame_seq", frame_seq, exp_q[0].seq);
          chk("frame_count", frame_count, exp_q[0].cnt);
          chk("frame_adr", frame_adr, exp_q[0].adr);
          if (frame_ready) begin
            void'(exp_q.pop_front());
            n_rx++;
          end
        end
      end
    end
  end

  initial begin
    set_adr(11'h7FF, 11'h7FF);
    ticks(2);
    chk("rst_valid", frame_valid, 0);
    chk("rst_count", frame_count, 0);
    chk("rst_seq", frame_seq, 0);
    chk("rst_half", frame_half, 0);
    chk("rst_adr", frame_adr, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_drop_cnt", drop_cnt, 0);
    chk("rst_order_err", order_err, 0);
    global_reset = 1'b0;
    // two hits held across one full phase cycle: one A and one B frame
    n_rx = 0;
    frame_ready = 1'b1;
    set_adr(5, 100);
    ticks(11);
    chk("t1_frames", n_rx, 2);
    // all eight slots valid and ascending
    for (int k = 0; k < 8; k++) adr[k] = 11'(10 * (k + 1));
    ticks(8);
    chk("t2_order_err", order_err, 0);
    // descending pair sets the sticky error, clr_status removes it
    set_adr(50, 40);
    ticks(8);
    set_adr(11'h7FF, 11'h7FF);
    ticks(3);
    chk("t3_order_err_set", order_err, 1);
    clr_status = 1'b1;
    tick();
    clr_status = 1'b0;
    chk("t3_order_err_clr", order_err, 0);
    // six samples into a stalled depth-4 FIFO
    do_reset();
    frame_ready = 1'b0;
    set_adr(7, 8);
    ticks(26);
    chk("t4_drop_cnt", drop_cnt, 2);
    chk("t4_overflow", overflow, 1);
    chk("t4_held", frame_valid, 1);
    set_adr(11'h7FF, 11'h7FF);
    frame_ready = 1'b1;
    ticks(8);
    // empty samples are discarded but still consume sequence numbers
    n_rx = 0;
    ticks(16);
    chk("t5_no_frames", n_rx, 0);
    set_adr(3, 11'h7FF);
    ticks(8);
    set_adr(11'h7FF, 11'h7FF);
    ticks(4);
    chk("t5_frames", n_rx, 2);
    // reset with frames buffered
    frame_ready = 1'b0;
    set_adr(1, 2);
    ticks(14);
    chk("t6_buffered", frame_valid, 1);
    do_reset();
    frame_ready = 1'b1;
    ticks(12);
    // drop counter saturation
    do_reset();
    frame_ready = 1'b0;
    set_adr(20, 30);
    ticks(8 * 132);
    chk("t7_drop_sat", drop_cnt, 255);
    frame_ready = 1'b1;
    ticks(8);
    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      rand_adr();
      frame_ready = $urandom_range(0, 9) < 7;
      clr_status = $urandom_range(0, 29) == 0;
      tick();
    end
    clr_status = 1'b0;
    frame_ready = 1'b1;
    set_adr(11'h7FF, 11'h7FF);
    ticks(16);
    chk("drain_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
